linear_layer_start_fifo_srl: RTL and testbench

- Start-token FIFO controller that sits directly upstream of the SRL storage primitive used between dataflow processes (e.g. the start channel feeding the PE_i4xi4 instances).
- Tracks occupancy and generates full_n/empty_n for the producer/consumer handshake.
- Drives the shift enable and read address of an internal SRL array.
- Presents the oldest entry combinationally on if_dout.

---
 rtl/linear_layer_start_fifo_srl.sv | 84 ++++++++
 tb/tb_linear_layer_start_fifo_srl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/linear_layer_start_fifo_srl.sv
// Start-token FIFO controller built around a shift-register (SRL) store.
// Tracks occupancy, drives registered full/empty flags and reads the head entry out of the SRL.
module linear_layer_start_fifo_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  // The array is padded to the full address range so every head address indexes a real entry.
  localparam int SRL_LEN = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] ZERO = {(ADDR_WIDTH+1){1'b0}};

  logic [DATA_WIDTH-1:0] srl_q [0:SRL_LEN-1];
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  full_n_q;
  logic                  full_n_d;
  logic                  empty_n_q;
  logic                  empty_n_d;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH:0]   addr_full_s;
  logic [ADDR_WIDTH-1:0] addr_s;

  assign push_s      = if_write & if_write_ce & full_n_q;
  assign pop_s       = if_read & if_read_ce & empty_n_q;
  assign addr_full_s = count_q - ONE;
  assign addr_s      = addr_full_s[ADDR_WIDTH-1:0];

  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
    full_n_d  = (count_d != CAP);
    empty_n_d = (count_d != ZERO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= ZERO;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  // Storage is deliberately unreset; validity comes only from count_q.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      for (int i = SRL_LEN - 1; i > 0; i--) begin
        srl_q[i] <= srl_q[i-1];
      end
      srl_q[0] <= if_din;
    end
  end

  assign if_dout           = srl_q[addr_s];
  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = CAP;

endmodule

// File: tb/tb_linear_layer_start_fifo_srl.sv
// Self-checking bench: directed steps from the test plan plus randomized traffic,
// compared against a queue-based reference model of the FIFO.
module tb_linear_layer_start_fifo_srl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset;
  logic          if_full_n;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_empty_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_num_data_valid;
  logic [AW:0]   if_fifo_cap;

  int errors;
  int checks;
  logic [DW-1:0] model_q[$];

  linear_layer_start_fifo_srl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    compare({tag, "_count"}, 32'(if_num_data_valid), 32'(model_q.size()));
    compare({tag, "_full_n"}, 32'(if_full_n), 32'(model_q.size() != DEPTH));
    compare({tag, "_empty_n"}, 32'(if_empty_n), 32'(model_q.size() != 0));
    if (model_q.size() > 0) compare({tag, "_dout"}, 32'(if_dout), 32'(model_q[0]));
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, then check just after the edge.
  task automatic step(input string tag, input logic w, input logic wce, input logic [DW-1:0] din,
                      input logic r, input logic rce, input logic rst);
    bit do_push;
    bit do_pop;
    if_write = w; if_write_ce = wce; if_din = din;
    if_read = r; if_read_ce = rce; reset = rst;
    do_push = w && wce && (model_q.size() < DEPTH);
    do_pop  = r && rce && (model_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(din);
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; if_write = 1'b0; if_write_ce = 1'b0; if_din = 8'h00;
    if_read = 1'b0; if_read_ce = 1'b0;

    // 1. reset
    step("rst0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("rst1", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    compare("fifo_cap", 32'(if_fifo_cap), 32'd4);
    compare("rst_count_const", 32'(if_num_data_valid), 32'd0);

    // 2. fill, then overflow attempt
    step("fill0", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step("fill1", 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step("fill2", 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step("fill3", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    compare("full_flag", 32'(if_full_n), 32'd0);
    step("ovf", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    compare("ovf_head", 32'(if_dout), 32'h11);

    // 3. drain and underflow attempt
    step("drain0", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    compare("drain0_head", 32'(if_dout), 32'h22);
    step("drain1", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step("drain2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    compare("drain2_head", 32'(if_dout), 32'h44);
    step("drain3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    step("udf", 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    compare("udf_count", 32'(if_num_data_valid), 32'd0);

    // 4. simultaneous push/pop at count=2
    step("pp_pre0", 1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    step("pp_pre1", 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    compare("pp_head0", 32'(if_dout), 32'hA0);
    step("pp0", 1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0);
    compare("pp_head1", 32'(if_dout), 32'hA1);
    step("pp1", 1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0);
    compare("pp_head2", 32'(if_dout), 32'hA2);
    step("pp2", 1'b1, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b0);
    compare("pp_count", 32'(if_num_data_valid), 32'd2);

    // 5. push&pop while empty, then while full
    step("rst_e", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step("pp_empty", 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    compare("pp_empty_head", 32'(if_dout), 32'h5A);
    step("f1", 1'b1, 1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
    step("f2", 1'b1, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b0);
    step("f3", 1'b1, 1'b1, 8'h5D, 1'b0, 1'b0, 1'b0);
    step("pp_full", 1'b1, 1'b1, 8'h5E, 1'b1, 1'b1, 1'b0);
    compare("pp_full_count", 32'(if_num_data_valid), 32'd3);
    compare("pp_full_head", 32'(if_dout), 32'h5B);

    // 6. reset mid-operation
    step("rst_mid", 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1);
    step("post_rst", 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    compare("post_rst_head", 32'(if_dout), 32'h77);

    // 7. clock-enables gate requests
    step("wce0", 1'b1, 1'b0, 8'h88, 1'b0, 1'b0, 1'b0);
    step("rce0", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    compare("ce_count", 32'(if_num_data_valid), 32'd1);

    // randomized traffic with biased phases to reach both full and empty
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 75 : 25;
      step("rnd",
           1'($urandom_range(99, 0) < wp), 1'($urandom_range(9, 0) != 0), 8'($urandom),
           1'($urandom_range(99, 0) < (100 - wp)), 1'($urandom_range(9, 0) != 0),
           1'($urandom_range(63, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
